// File: rtl/pll_clock_monitor.sv
// rtl/pll_clock_monitor.sv - PLL reset sequencer, lock qualifier and output frequency checker
module pll_clock_monitor #(
   parameter int RST_CYCLES   = 16,
   parameter int LOCK_STABLE  = 1024,
   parameter int LOCK_TIMEOUT = 500000,
   parameter int GATE_CYCLES  = 50000,
   parameter int EXP_COUNT    = 1172,
   parameter int TOL          = 2
) (
   input  logic        refclk,
   input  logic        rst,
   input  logic        locked,
   input  logic        outclk_in,
   output logic        pll_rst,
   output logic        clk_ok,
   output logic        fault,
   output logic [15:0] freq_count,
   output logic [3:0]  retries
);

   localparam int CMAX = (RST_CYCLES > LOCK_TIMEOUT)
                         ? ((RST_CYCLES > GATE_CYCLES) ? RST_CYCLES : GATE_CYCLES)
                         : ((LOCK_TIMEOUT > GATE_CYCLES) ? LOCK_TIMEOUT : GATE_CYCLES);
   localparam int CW = $clog2(CMAX + 1);
   localparam int SW = $clog2(LOCK_STABLE + 1);
   localparam logic [31:0] LO = (EXP_COUNT > TOL) ? 32'(EXP_COUNT - TOL) : 32'd0;
   localparam logic [31:0] HI = 32'(EXP_COUNT + TOL);

   typedef enum logic [1:0] {RESET_PLL, WAIT_LOCK, MEASURE, RUN} state_t;

   state_t         state;
   logic           lock_s1, lock_s2;
   logic           oc_s1, oc_s2, oc_s3;
   logic [CW-1:0]  cnt;
   logic [SW-1:0]  stable;
   logic [15:0]    edges;
   logic           edge_det;
   logic [15:0]    edges_next;
   logic [3:0]     retries_next;
   logic           in_range;

   assign edge_det     = oc_s2 & ~oc_s3;
   assign edges_next   = (edges == 16'hFFFF) ? edges : edges + {15'd0, edge_det};
   assign retries_next = (retries == 4'hF) ? retries : retries + 4'd1;
   assign in_range     = ({16'd0, edges_next} >= LO) && ({16'd0, edges_next} <= HI);

   // cnt is shared: reset pulse length, lock timeout, then measurement gate
   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         state      <= RESET_PLL;
         lock_s1    <= 1'b0;
         lock_s2    <= 1'b0;
         oc_s1      <= 1'b0;
         oc_s2      <= 1'b0;
         oc_s3      <= 1'b0;
         cnt        <= '0;
         stable     <= '0;
         edges      <= '0;
         pll_rst    <= 1'b1;
         clk_ok     <= 1'b0;
         fault      <= 1'b0;
         freq_count <= '0;
         retries    <= '0;
      end else begin
         lock_s1 <= locked;
         lock_s2 <= lock_s1;
         oc_s1   <= outclk_in;
         oc_s2   <= oc_s1;
         oc_s3   <= oc_s2;
         case (state)
            RESET_PLL: begin
               if (cnt == CW'(RST_CYCLES - 1)) begin
                  state   <= WAIT_LOCK;
                  pll_rst <= 1'b0;
                  cnt     <= '0;
                  stable  <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            WAIT_LOCK: begin
               cnt <= cnt + 1'b1;
               if (lock_s2 && stable == SW'(LOCK_STABLE - 1)) begin
                  state <= MEASURE;
                  cnt   <= '0;
                  edges <= '0;
               end else if (cnt == CW'(LOCK_TIMEOUT - 1)) begin
                  state   <= RESET_PLL;
                  pll_rst <= 1'b1;
                  cnt     <= '0;
                  retries <= retries_next;
               end else begin
                  stable <= lock_s2 ? stable + 1'b1 : '0;
               end
            end
            MEASURE, RUN: begin
               // lock loss wins over a coincident window end
               if (!lock_s2 || (cnt == CW'(GATE_CYCLES - 1) && !in_range)) begin
                  if (lock_s2) freq_count <= edges_next;
                  state   <= RESET_PLL;
                  pll_rst <= 1'b1;
                  clk_ok  <= 1'b0;
                  fault   <= 1'b1;
                  retries <= retries_next;
                  cnt     <= '0;
                  edges   <= '0;
               end else if (cnt == CW'(GATE_CYCLES - 1)) begin
                  freq_count <= edges_next;
                  edges      <= '0;
                  cnt        <= '0;
                  state      <= RUN;
                  clk_ok     <= 1'b1;
               end else begin
                  cnt   <= cnt + 1'b1;
                  edges <= edges_next;
               end
            end
            default: state <= RESET_PLL;
         endcase
      end
   end

endmodule

// File: tb/tb_pll_clock_monitor.sv
// tb/tb_pll_clock_monitor.sv - directed self-checking bench for pll_clock_monitor
module tb_pll_clock_monitor;

   logic        refclk = 1'b0;
   logic        rst = 1'b1;
   logic        locked = 1'b0;
   logic        outclk_in = 1'b0;
   logic        pll_rst, clk_ok, fault;
   logic [15:0] freq_count;
   logic [3:0]  retries;

   int vectors = 0;
   int errors = 0;
   int oc_period = 10;
   int ph = 0;
   int n;

   pll_clock_monitor #(
      .RST_CYCLES(4), .LOCK_STABLE(8), .LOCK_TIMEOUT(64),
      .GATE_CYCLES(100), .EXP_COUNT(10), .TOL(1)
   ) dut (
      .refclk(refclk), .rst(rst), .locked(locked), .outclk_in(outclk_in),
      .pll_rst(pll_rst), .clk_ok(clk_ok), .fault(fault),
      .freq_count(freq_count), .retries(retries)
   );

   always #10 refclk = ~refclk;

   // outclk_in modelled as data with a period counted in refclk cycles
   initial forever begin
      @(negedge refclk);
      ph = ph + 1;
      if (ph >= oc_period) ph = 0;
      outclk_in = (ph < oc_period / 2);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_pll_rst"}, 32'(pll_rst), 1);
      chk({tag, "_clk_ok"}, 32'(clk_ok), 0);
      chk({tag, "_fault"}, 32'(fault), 0);
      chk({tag, "_freq"}, 32'(freq_count), 0);
      chk({tag, "_retries"}, 32'(retries), 0);
   endtask

   task automatic do_reset();
      @(negedge refclk);
      rst = 1'b1;
      repeat (3) @(negedge refclk);
      chk_reset_vals("reset_hold");
      rst = 1'b0;
   endtask

   task automatic wait_clk_ok(input string tag, input int bound);
      int k;
      for (k = 0; k < bound && !clk_ok; k++) @(negedge refclk);
      chk(tag, 32'(clk_ok), 1);
   endtask

   initial begin
      // reset state
      locked = 1'b1;
      repeat (2) @(negedge refclk);
      chk_reset_vals("init");

      // nominal: exact pll_rst pulse and RUN entry timing
      rst = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         @(negedge refclk);
         chk("nom_pll_rst_high", 32'(pll_rst), 1);
      end
      @(negedge refclk);
      chk("nom_pll_rst_low", 32'(pll_rst), 0);
      n = 4;
      while (!clk_ok && n < 200) begin
         @(negedge refclk);
         n++;
      end
      chk("nom_run_cycle", 32'(n), 112);
      chk("nom_freq", 32'(freq_count), 10);
      chk("nom_fault", 32'(fault), 0);
      chk("nom_retries", 32'(retries), 0);

      // reset at cycle 50 of the second window
      repeat (50) @(negedge refclk);
      chk("mid_clk_ok_before", 32'(clk_ok), 1);
      chk("mid_freq_before", 32'(freq_count), 10);
      rst = 1'b1;
      #1;
      chk_reset_vals("midwin");

      // wrong frequency: period 8 gives 12 or 13 edges per window
      oc_period = 8;
      do_reset();
      n = 0;
      while (!fault && n < 200) begin
         @(negedge refclk);
         n++;
      end
      chk("wf_fault_cycle", 32'(n), 112);
      chk("wf_fault", 32'(fault), 1);
      chk("wf_retries", 32'(retries), 1);
      chk("wf_pll_rst", 32'(pll_rst), 1);
      chk("wf_clk_ok", 32'(clk_ok), 0);
      chk("wf_freq_range", 32'(freq_count >= 12 && freq_count <= 13), 1);
      oc_period = 10;
      wait_clk_ok("wf_recover_run", 300);
      chk("wf_recover_freq", 32'(freq_count), 10);
      chk("wf_fault_sticky", 32'(fault), 1);
      chk("wf_recover_retries", 32'(retries), 1);

      // lock loss in RUN for 3 cycles
      repeat (20) @(negedge refclk);
      locked = 1'b0;
      n = 0;
      while (clk_ok && n < 5) begin
         @(negedge refclk);
         n++;
      end
      chk("ll_latency_ok", 32'(n >= 1 && n <= 3), 1);
      chk("ll_clk_ok", 32'(clk_ok), 0);
      chk("ll_pll_rst", 32'(pll_rst), 1);
      chk("ll_fault", 32'(fault), 1);
      chk("ll_retries", 32'(retries), 2);
      chk("ll_freq_hold", 32'(freq_count), 10);
      repeat (3 - n) @(negedge refclk);
      locked = 1'b1;
      wait_clk_ok("ll_recover_run", 300);

      // no lock: retry every 68 cycles, retries saturating at 15
      locked = 1'b0;
      do_reset();
      repeat (67) @(negedge refclk);
      chk("nl_67_pll_rst", 32'(pll_rst), 0);
      chk("nl_67_retries", 32'(retries), 0);
      @(negedge refclk);
      chk("nl_68_pll_rst", 32'(pll_rst), 1);
      chk("nl_68_retries", 32'(retries), 1);
      repeat (3) @(negedge refclk);
      chk("nl_71_pll_rst", 32'(pll_rst), 1);
      @(negedge refclk);
      chk("nl_72_pll_rst", 32'(pll_rst), 0);
      repeat (64) @(negedge refclk);
      chk("nl_136_retries", 32'(retries), 2);
      repeat (1020 - 136) @(negedge refclk);
      chk("nl_1020_retries", 32'(retries), 15);
      repeat (200) @(negedge refclk);
      chk("nl_sat_retries", 32'(retries), 15);
      chk("nl_clk_ok", 32'(clk_ok), 0);

      // glitchy lock: period-6 toggling never reaches 8 stable cycles
      do_reset();
      for (int i = 0; i < 70; i++) begin
         locked = ((i / 3) % 2 == 0);
         @(negedge refclk);
      end
      chk("gl_retries", 32'(retries), 1);
      chk("gl_clk_ok", 32'(clk_ok), 0);
      locked = 1'b1;
      wait_clk_ok("gl_run", 300);
      chk("gl_freq", 32'(freq_count), 10);
      chk("gl_fault", 32'(fault), 0);
      chk("gl_retries_after", 32'(retries), 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/pll_clock_monitor.md
PLL_CLOCK_MONITOR -- requirements
Module: pll_clock_monitor

Interface
REQ-001 SHALL have parameter RST_CYCLES, default 16: number of refclk cycles pll_rst is held high per reset attempt.
REQ-002 SHALL have parameter LOCK_STABLE, default 1024: consecutive refclk cycles of synchronized locked=1 required to accept lock.
REQ-003 SHALL have parameter LOCK_TIMEOUT, default 500000: refclk cycles allowed in WAIT_LOCK before a retry.
REQ-004 SHALL have parameter GATE_CYCLES, default 50000: measurement window length in refclk cycles (1 ms at 50 MHz).
REQ-005 SHALL have parameter EXP_COUNT, default 1172: expected outclk rising edges per window (1.171875 MHz).
REQ-006 SHALL have parameter TOL, default 2: allowed deviation of the edge count from EXP_COUNT.
REQ-007 refclk  input  1  sole clock, 50 MHz; all state is on its rising edge.
REQ-008 rst  input  1  reset, asynchronous, active-high.
REQ-009 locked  input  1  PLL lock flag, asynchronous to refclk.
REQ-010 outclk_in  input  1  PLL output clock, sampled as data, never used as a clock.
REQ-011 pll_rst  output  1  reset to the PLL, active-high.
REQ-012 clk_ok  output  1  high only in RUN.
REQ-013 fault  output  1  sticky error flag.
REQ-014 freq_count  output  16  edge count of the last completed window.
REQ-015 retries  output  4  number of PLL reset attempts after the first, saturating at 15.

Function
REQ-016 locked and outclk_in SHALL each pass through a 2-flop synchronizer; a third flop on outclk_in SHALL provide rising-edge detection (sync=1, delayed=0).
REQ-017 The FSM SHALL have states RESET_PLL, WAIT_LOCK, MEASURE, RUN.
REQ-018 RESET_PLL: pll_rst=1 for exactly RST_CYCLES cycles, then go to WAIT_LOCK with pll_rst=0.
REQ-019 WAIT_LOCK: stable counter increments while synced locked=1 and clears to 0 when it is 0; reaching LOCK_STABLE goes to MEASURE.
REQ-020 WAIT_LOCK: after LOCK_TIMEOUT cycles without lock, go to RESET_PLL and increment retries (saturating).
REQ-021 MEASURE and RUN: a gate counter counts GATE_CYCLES cycles. On the last cycle, freq_count SHALL load the window edge count, including an edge detected in that cycle. The edge counter SHALL then restart from 0.
REQ-022 The edge counter SHALL saturate at 16'hFFFF.
REQ-023 At window end, the count is in range when EXP_COUNT-TOL <= count <= EXP_COUNT+TOL, using unsigned compare with the lower bound clamped at 0.
REQ-024 In range at window end in MEASURE: go to RUN. In range at window end in RUN: stay in RUN.
REQ-025 Out of range at window end in either state: set fault, increment retries, go to RESET_PLL.
REQ-026 Synced locked=0 for 1 cycle in MEASURE or RUN: set fault, increment retries, go to RESET_PLL. This takes priority over a window end in the same cycle.
REQ-027 clk_ok SHALL be registered and equal 1 exactly while state is RUN; it drops on the same edge the state leaves RUN.
REQ-028 fault SHALL stay 1 until rst; it does not block retries.
REQ-029 freq_count SHALL hold its value outside window end, including across retries.

Reset
REQ-030 While rst=1: state=RESET_PLL, pll_rst=1, clk_ok=0, fault=0, freq_count=0, retries=0, and all counters and synchronizers are 0.
REQ-031 rst is asynchronous assert, synchronous deassert, from the consumer's view. After rst falls, the RST_CYCLES count starts on the first refclk edge.
REQ-032 rst asserted mid-window SHALL discard the partial count and leave freq_count at 0.

Verification
REQ-033 Bench uses small parameters: RST_CYCLES=4, LOCK_STABLE=8, LOCK_TIMEOUT=64, GATE_CYCLES=100, EXP_COUNT=10, TOL=1. outclk_in period is 10 refclk cycles unless stated.
REQ-034 Scenario nominal: locked=1 from the start. Expect pll_rst high 4 cycles, clk_ok=1 after the first window, freq_count=10, fault=0, retries=0.
REQ-035 Scenario no lock: locked held 0. Expect pll_rst re-pulsed every 4+64 cycles, retries stepping 1..15 and holding at 15, clk_ok=0.
REQ-036 Scenario glitchy lock: locked toggles with period 6 (never 8 stable). Expect a timeout retry; then hold locked=1 and expect normal entry to RUN.
REQ-037 Scenario wrong frequency: outclk_in period 8 (count 12-13). Expect fault=1, retries=1, return to RESET_PLL. Restore period 10 and expect RUN again with fault still 1.
REQ-038 Scenario lock loss in RUN: drop locked for 3 cycles. Expect clk_ok=0 and pll_rst=1 within 3 cycles of the drop (synchronizer latency), fault=1, freq_count unchanged.
REQ-039 Scenario reset mid-window: assert rst at cycle 50 of a window. Expect all outputs at reset values immediately and freq_count=0.
